// File: rtl/calc_alu_sched.sv
// rtl/calc_alu_sched.sv - operation sequencer for the calculator's shared add/sub/mul/div datapath
// Optional CALC_MOD_EN adds '%' (remainder) on the divide iteration.
module calc_alu_sched #(
   parameter int WIDTH = 16,
   parameter int CNT_W = 5
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [WIDTH-1:0] operand_a,
   input  logic [WIDTH-1:0] operand_b,
   input  logic [7:0]       op_char,
   input  logic             abort,
   output logic             busy,
   output logic [WIDTH-1:0] result_value,
   output logic             result_valid,
   output logic             err_ovf,
   output logic             err_div0,
   output logic             err_op
);

   typedef enum logic [1:0] {S_IDLE, S_EXEC, S_ITER, S_DONE} state_t;
   typedef enum logic [2:0] {K_ADD, K_SUB, K_MUL, K_DIV, K_MOD, K_BAD} kind_t;

   localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

   state_t               r_state;
   kind_t                r_kind;
   logic [WIDTH-1:0]     r_a;
   logic [WIDTH-1:0]     r_b;
   logic [2*WIDTH-1:0]   r_x;
   logic [2*WIDTH-1:0]   r_acc;
   logic [WIDTH-1:0]     r_y;
   logic [WIDTH-1:0]     r_rem;
   logic [CNT_W-1:0]     r_cnt;
   logic [WIDTH-1:0]     r_result;
   logic                 r_valid;
   logic                 r_ovf;
   logic                 r_div0;
   logic                 r_op_err;

   kind_t                w_kind;
   logic [WIDTH:0]       w_sum;
   logic [WIDTH-1:0]     w_diff;
   logic [2*WIDTH-1:0]   w_acc_next;
   logic [WIDTH:0]       w_shift;
   logic [WIDTH:0]       w_sub;
   logic                 w_ge;
   logic [WIDTH-1:0]     w_rem_next;
   logic [WIDTH-1:0]     w_quo_next;
   logic                 w_is_div;

   always_comb begin
      w_kind = K_BAD;
      case (op_char)
         8'h2B:   w_kind = K_ADD;
         8'h2D:   w_kind = K_SUB;
         8'h2A:   w_kind = K_MUL;
         8'h2F:   w_kind = K_DIV;
`ifdef CALC_MOD_EN
         8'h25:   w_kind = K_MOD;
`else
`endif
         default: w_kind = K_BAD;
      endcase
   end

   assign w_is_div   = (w_kind == K_DIV) || (w_kind == K_MOD);
   assign w_sum      = {1'b0, r_a} + {1'b0, r_b};
   assign w_diff     = r_a - r_b;
   assign w_acc_next = r_acc + (r_y[0] ? r_x : '0);

   // Restoring divide: r_y shifts the dividend out MSB-first while quotient bits shift in.
   assign w_shift    = {r_rem, r_y[WIDTH-1]};
   assign w_sub      = w_shift - {1'b0, r_b};
   assign w_ge       = (w_shift >= {1'b0, r_b});
   assign w_rem_next = w_ge ? w_sub[WIDTH-1:0] : w_shift[WIDTH-1:0];
   assign w_quo_next = {r_y[WIDTH-2:0], w_ge};

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state  <= S_IDLE;
         r_kind   <= K_ADD;
         r_a      <= '0;
         r_b      <= '0;
         r_x      <= '0;
         r_acc    <= '0;
         r_y      <= '0;
         r_rem    <= '0;
         r_cnt    <= '0;
         r_result <= '0;
         r_valid  <= 1'b0;
         r_ovf    <= 1'b0;
         r_div0   <= 1'b0;
         r_op_err <= 1'b0;
      end else begin
         r_valid <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (req_valid) begin
                  r_kind   <= w_kind;
                  r_a      <= operand_a;
                  r_b      <= operand_b;
                  r_x      <= {{WIDTH{1'b0}}, operand_a};
                  r_y      <= (w_kind == K_MUL) ? operand_b : operand_a;
                  r_acc    <= '0;
                  r_rem    <= '0;
                  r_cnt    <= '0;
                  r_ovf    <= 1'b0;
                  r_div0   <= 1'b0;
                  r_op_err <= 1'b0;
                  if (w_is_div && (operand_b == '0)) begin
                     r_result <= (w_kind == K_DIV) ? '1 : operand_a;
                     r_div0   <= 1'b1;
                     r_valid  <= 1'b1;
                     r_state  <= S_DONE;
                  end else if (w_is_div || (w_kind == K_MUL)) begin
                     r_state <= S_ITER;
                  end else begin
                     r_state <= S_EXEC;
                  end
               end
            end
            S_EXEC: begin
               if (abort) begin
                  r_state <= S_IDLE;
               end else begin
                  case (r_kind)
                     K_ADD: begin
                        r_result <= w_sum[WIDTH-1:0];
                        r_ovf    <= w_sum[WIDTH];
                     end
                     K_SUB: begin
                        r_result <= w_diff;
                        r_ovf    <= (r_a < r_b);
                     end
                     default: begin
                        r_result <= '0;
                        r_op_err <= 1'b1;
                     end
                  endcase
                  r_valid <= 1'b1;
                  r_state <= S_DONE;
               end
            end
            S_ITER: begin
               if (abort) begin
                  r_state <= S_IDLE;
               end else begin
                  r_cnt <= r_cnt + CNT_W'(1);
                  if (r_kind == K_MUL) begin
                     r_acc <= w_acc_next;
                     r_x   <= r_x << 1;
                     r_y   <= r_y >> 1;
                  end else begin
                     r_rem <= w_rem_next;
                     r_y   <= w_quo_next;
                  end
                  if (r_cnt == LAST) begin
                     if (r_kind == K_MUL) begin
                        r_result <= w_acc_next[WIDTH-1:0];
                        r_ovf    <= |w_acc_next[2*WIDTH-1:WIDTH];
                     end else if (r_kind == K_MOD) begin
                        r_result <= w_rem_next;
                     end else begin
                        r_result <= w_quo_next;
                     end
                     r_valid <= 1'b1;
                     r_state <= S_DONE;
                  end
               end
            end
            S_DONE:  r_state <= S_IDLE;
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign req_ready    = (r_state == S_IDLE);
   assign busy         = ~req_ready;
   assign result_value = r_result;
   assign result_valid = r_valid;
   assign err_ovf      = r_ovf;
   assign err_div0     = r_div0;
   assign err_op       = r_op_err;

endmodule

// File: tb/tb_calc_alu_sched.sv
// tb/tb_calc_alu_sched.sv - directed vector bench for calc_alu_sched
module tb_calc_alu_sched;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req_valid;
   logic        req_ready;
   logic [15:0] operand_a;
   logic [15:0] operand_b;
   logic [7:0]  op_char;
   logic        abort;
   logic        busy;
   logic [15:0] result_value;
   logic        result_valid;
   logic        err_ovf;
   logic        err_div0;
   logic        err_op;

   int checks = 0;
   int errors = 0;
   logic [15:0] last_exp = 16'h0;

   typedef struct {
      logic [7:0]  op;
      logic [15:0] a;
      logic [15:0] b;
      logic [15:0] res;
      logic        ovf;
      logic        div0;
      logic        eop;
      int          lat;
   } vec_t;

   vec_t tbl[16];

   calc_alu_sched #(.WIDTH(16), .CNT_W(5)) dut (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
      .operand_a(operand_a), .operand_b(operand_b), .op_char(op_char), .abort(abort),
      .busy(busy), .result_value(result_value), .result_valid(result_valid),
      .err_ovf(err_ovf), .err_div0(err_div0), .err_op(err_op)
   );

   always #15 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, " ready"}, {31'b0, req_ready}, 32'd1);
      check({tag, " busy"}, {31'b0, busy}, 32'd0);
      check({tag, " value"}, {16'b0, result_value}, 32'd0);
      check({tag, " valid"}, {31'b0, result_valid}, 32'd0);
      check({tag, " errs"}, {29'b0, err_ovf, err_div0, err_op}, 32'd0);
   endtask

   // Presents a request at a negedge; the first negedge after the accepting edge counts as latency 1.
   task automatic start_req(input logic [7:0] op, input logic [15:0] a, input logic [15:0] b);
      @(negedge clk);
      req_valid = 1'b1;
      op_char   = op;
      operand_a = a;
      operand_b = b;
      @(negedge clk);
      req_valid = 1'b0;
   endtask

   task automatic run_vec(input vec_t v, input int idx);
      int n;
      string tag;
      tag = $sformatf("vec%0d op%0h", idx, v.op);
      start_req(v.op, v.a, v.b);
      check({tag, " busy_after_accept"}, {31'b0, req_ready}, 32'd0);
      n = 1;
      while (!result_valid && n < 40) begin
         @(negedge clk);
         n++;
      end
      check({tag, " latency"}, n, v.lat);
      check({tag, " result"}, {16'b0, result_value}, {16'b0, v.res});
      check({tag, " flags"}, {29'b0, err_ovf, err_div0, err_op}, {29'b0, v.ovf, v.div0, v.eop});
      @(negedge clk);
      check({tag, " pulse_one_cycle"}, {31'b0, result_valid}, 32'd0);
      check({tag, " ready_after"}, {31'b0, req_ready}, 32'd1);
      check({tag, " result_hold"}, {16'b0, result_value}, {16'b0, v.res});
      last_exp = v.res;
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int seen;
      vec_t v;
      tbl[0]  = '{8'h2B, 16'd7,     16'd5,     16'd12,    1'b0, 1'b0, 1'b0, 2};
      tbl[1]  = '{8'h2D, 16'd3,     16'd5,     16'hFFFE,  1'b1, 1'b0, 1'b0, 2};
      tbl[2]  = '{8'h2B, 16'hFFFF,  16'd1,     16'h0000,  1'b1, 1'b0, 1'b0, 2};
      tbl[3]  = '{8'h2D, 16'd5,     16'd3,     16'd2,     1'b0, 1'b0, 1'b0, 2};
      tbl[4]  = '{8'h2B, 16'h8000,  16'h8000,  16'h0000,  1'b1, 1'b0, 1'b0, 2};
      tbl[5]  = '{8'h2A, 16'd300,   16'd300,   16'h5F90,  1'b1, 1'b0, 1'b0, 17};
      tbl[6]  = '{8'h2A, 16'd255,   16'd3,     16'd765,   1'b0, 1'b0, 1'b0, 17};
      tbl[7]  = '{8'h2A, 16'hFFFF,  16'hFFFF,  16'h0001,  1'b1, 1'b0, 1'b0, 17};
      tbl[8]  = '{8'h2F, 16'd100,   16'd7,     16'd14,    1'b0, 1'b0, 1'b0, 17};
      tbl[9]  = '{8'h2F, 16'd5,     16'd0,     16'hFFFF,  1'b0, 1'b1, 1'b0, 1};
      tbl[10] = '{8'h2F, 16'hFFFF,  16'd1,     16'hFFFF,  1'b0, 1'b0, 1'b0, 17};
      tbl[11] = '{8'h2F, 16'd7,     16'd100,   16'd0,     1'b0, 1'b0, 1'b0, 17};
      tbl[12] = '{8'h78, 16'd1,     16'd2,     16'd0,     1'b0, 1'b0, 1'b1, 2};
      tbl[13] = '{8'h2A, 16'd0,     16'd1234,  16'd0,     1'b0, 1'b0, 1'b0, 17};
`ifdef CALC_MOD_EN
      tbl[14] = '{8'h25, 16'd100,   16'd7,     16'd2,     1'b0, 1'b0, 1'b0, 17};
      tbl[15] = '{8'h25, 16'd9,     16'd0,     16'd9,     1'b0, 1'b1, 1'b0, 1};
`else
      tbl[14] = '{8'h25, 16'd100,   16'd7,     16'd0,     1'b0, 1'b0, 1'b1, 2};
      tbl[15] = '{8'h2F, 16'd50000, 16'd123,   16'd406,   1'b0, 1'b0, 1'b0, 17};
`endif

      rst_n = 1'b0;
      req_valid = 1'b0;
      operand_a = '0;
      operand_b = '0;
      op_char = 8'h00;
      abort = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_reset_outputs("reset");
      rst_n = 1'b1;

      for (int i = 0; i < 16; i++) begin
         v = tbl[i];
         run_vec(v, i);
      end

      // Abort during a multiply: no pulse, value held, next request accepted immediately.
      abort = 1'b1;
      @(negedge clk);
      check("abort_idle ready", {31'b0, req_ready}, 32'd1);
      abort = 1'b0;
      start_req(8'h2A, 16'd9, 16'd9);
      seen = 0;
      for (int k = 1; k < 5; k++) begin
         if (result_valid) seen++;
         @(negedge clk);
      end
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      check("abort busy_cleared", {31'b0, busy}, 32'd0);
      check("abort no_pulse", seen + int'(result_valid), 32'd0);
      check("abort value_held", {16'b0, result_value}, {16'b0, last_exp});
      v = '{8'h2B, 16'd1, 16'd2, 16'd3, 1'b0, 1'b0, 1'b0, 2};
      run_vec(v, 100);

      // Reset in the middle of a divide iteration.
      start_req(8'h2F, 16'd1000, 16'd3);
      repeat (4) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      check_reset_outputs("midreset");
      rst_n = 1'b1;
      seen = 0;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         if (result_valid) seen++;
      end
      check("midreset no_pulse", seen, 32'd0);
      v = '{8'h2F, 16'd1000, 16'd3, 16'd333, 1'b0, 1'b0, 1'b0, 17};
      run_vec(v, 101);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
